// File: rtl/approx_adder_eval_pipe.sv
// approx_adder_eval_pipe
//   Two-stage pipelined approximate adder with error accounting. Each
//   operand pair produces an approximate sum (mode chosen per transaction),
//   the exact sum, and the absolute difference between them. Running
//   statistics are accumulated over completed output handshakes.
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_a, in_b, in_mode sampled on accept
//   out_valid/out_ready : result handshake; out_sum, out_exact, out_err
//   stat_clear          : synchronous clear of every statistic
//   stat_samples        : completed output handshakes (saturating)
//   stat_errors         : handshakes with nonzero error (saturating)
//   stat_max_err        : largest error seen
//   stat_sum_err        : saturating sum of errors
//   stat_sat            : sticky flag, set when any statistic saturates
module approx_adder_eval_pipe #(
  parameter int WIDTH      = 16,
  parameter int APPROX_LSB = 6,
  parameter int ERR_W      = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_exact,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_errors,
  output logic [WIDTH:0]   stat_max_err,
  output logic [ERR_W-1:0] stat_sum_err,
  output logic             stat_sat
);

  localparam int L    = APPROX_LSB;
  localparam int HI_W = WIDTH - APPROX_LSB;
  // Wide enough to hold sum_err + err without wrapping, whichever is wider.
  localparam int SW   = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
  localparam logic [SW-1:0] SUM_LIMIT = {{(SW-ERR_W){1'b0}}, {ERR_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_LOR   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Stage 1
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  mode_e            s1_mode_q, s1_mode_d;

  // Stage 2
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d;
  logic [WIDTH:0]   s2_exact_q, s2_exact_d;
  logic [WIDTH:0]   s2_err_q, s2_err_d;

  // Statistics
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [WIDTH:0]   max_err_q, max_err_d;
  logic [ERR_W-1:0] sum_err_q, sum_err_d;
  logic             sat_q, sat_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             out_hs;
  logic [WIDTH:0]   exact_c;
  logic [WIDTH:0]   approx_c;
  logic [WIDTH:0]   err_c;
  logic [HI_W:0]    hi_sum_c;
  logic [SW-1:0]    sum_wide_c;

  // Handshake control: S1 may refill in the same cycle S2 drains it.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    out_hs   = s2_valid_q && out_ready;
  end

  // Arithmetic on the S1 contents
  always_comb begin
    exact_c  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    // Upper part only; no carry is allowed to cross into bit L.
    hi_sum_c = {1'b0, s1_a_q[WIDTH-1:L]} + {1'b0, s1_b_q[WIDTH-1:L]};
    unique case (s1_mode_q)
      MODE_TRUNC: approx_c = {hi_sum_c, {L{1'b0}}};
      MODE_LOR:   approx_c = {hi_sum_c, s1_a_q[L-1:0] | s1_b_q[L-1:0]};
      default:    approx_c = exact_c;
    endcase
    err_c = (exact_c >= approx_c) ? (exact_c - approx_c) : (approx_c - exact_c);
  end

  // Pipeline next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_mode_d = mode_e'(in_mode);
      end
    end

    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_exact_d = s2_exact_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d   = approx_c;
        s2_exact_d = exact_c;
        s2_err_d   = err_c;
      end
    end
  end

  // Statistics next-state; clear takes priority over a coincident handshake.
  always_comb begin
    samples_d  = samples_q;
    errors_d   = errors_q;
    max_err_d  = max_err_q;
    sum_err_d  = sum_err_q;
    sat_d      = sat_q;
    sum_wide_c = {{(SW-ERR_W){1'b0}}, sum_err_q} + {{(SW-WIDTH-1){1'b0}}, s2_err_q};
    if (stat_clear) begin
      samples_d = '0;
      errors_d  = '0;
      max_err_d = '0;
      sum_err_d = '0;
      sat_d     = 1'b0;
    end else if (out_hs) begin
      if (samples_q == '1) sat_d = 1'b1;
      else                 samples_d = samples_q + CNT_W'(1);
      if (s2_err_q != '0) begin
        if (errors_q == '1) sat_d = 1'b1;
        else                errors_d = errors_q + CNT_W'(1);
      end
      if (s2_err_q > max_err_q) max_err_d = s2_err_q;
      if (sum_wide_c > SUM_LIMIT) begin
        sum_err_d = '1;
        sat_d     = 1'b1;
      end else begin
        sum_err_d = sum_wide_c[ERR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_EXACT;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_exact_q <= '0;
      s2_err_q   <= '0;
      samples_q  <= '0;
      errors_q   <= '0;
      max_err_q  <= '0;
      sum_err_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_exact_q <= s2_exact_d;
      s2_err_q   <= s2_err_d;
      samples_q  <= samples_d;
      errors_q   <= errors_d;
      max_err_q  <= max_err_d;
      sum_err_q  <= sum_err_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_sum      = s2_sum_q;
  assign out_exact    = s2_exact_q;
  assign out_err      = s2_err_q;
  assign stat_samples = samples_q;
  assign stat_errors  = errors_q;
  assign stat_max_err = max_err_q;
  assign stat_sum_err = sum_err_q;
  assign stat_sat     = sat_q;

endmodule

// File: tb/tb_approx_adder_eval_pipe.sv
// Testbench for approx_adder_eval_pipe: a default instance (ERR_W=32) and a
// narrow-accumulator instance (ERR_W=8) share all inputs. A queue-based
// reference model predicts every output on every cycle.
module tb_approx_adder_eval_pipe;

  localparam int W = 16;
  localparam int L = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_mode;
  logic          out_ready;
  logic          stat_clear;

  logic          in_ready, out_valid, stat_sat;
  logic [W:0]    out_sum, out_exact, out_err, stat_max_err;
  logic [31:0]   stat_samples, stat_errors, stat_sum_err;

  logic          in_ready8, out_valid8, stat_sat8;
  logic [W:0]    out_sum8, out_exact8, out_err8, stat_max_err8;
  logic [31:0]   stat_samples8, stat_errors8;
  logic [7:0]    stat_sum_err8;

  always #5 clk = ~clk;

  approx_adder_eval_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_exact(out_exact), .out_err(out_err),
    .stat_clear(stat_clear), .stat_samples(stat_samples), .stat_errors(stat_errors),
    .stat_max_err(stat_max_err), .stat_sum_err(stat_sum_err), .stat_sat(stat_sat)
  );

  approx_adder_eval_pipe #(.ERR_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_exact(out_exact8), .out_err(out_err8),
    .stat_clear(stat_clear), .stat_samples(stat_samples8), .stat_errors(stat_errors8),
    .stat_max_err(stat_max_err8), .stat_sum_err(stat_sum_err8), .stat_sat(stat_sat8)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint sum;
    longint exact;
    longint err;
    int     acc;
  } item_t;

  item_t  q[$];
  longint m_samples, m_errors, m_max, m_sum, m_sum8;
  bit     m_sat, m_sat8;

  function automatic item_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] m, input int acc);
    item_t  it;
    longint ua, ub, hi, lo;
    ua = longint'(a);
    ub = longint'(b);
    hi = (ua >> L) + (ub >> L);
    lo = (ua | ub) % (64'd1 << L);
    it.exact = ua + ub;
    case (m)
      2'd1:    it.sum = hi * (64'd1 << L);
      2'd2:    it.sum = hi * (64'd1 << L) + lo;
      default: it.sum = ua + ub;
    endcase
    it.err = (it.exact > it.sum) ? it.exact - it.sum : it.sum - it.exact;
    it.acc = acc;
    return it;
  endfunction

  task automatic model_clear_stats();
    m_samples = 0; m_errors = 0; m_max = 0; m_sum = 0; m_sum8 = 0;
    m_sat = 0; m_sat8 = 0;
  endtask

  initial begin : monitor
    int    last_pop;
    bit    just_rst;
    bit    ev;
    bit    exp_ready;
    int    vis;
    item_t h;
    last_pop = -100;
    just_rst = 1'b0;
    model_clear_stats();
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        model_clear_stats();
        last_pop = -100;
        just_rst = 1'b1;
      end else begin
        chk("stat_samples", stat_samples, m_samples);
        chk("stat_errors", stat_errors, m_errors);
        chk("stat_max_err", stat_max_err, m_max);
        chk("stat_sum_err", stat_sum_err, m_sum);
        chk("stat_sat", stat_sat, m_sat);
        chk("stat_sum_err8", stat_sum_err8, m_sum8);
        chk("stat_sat8", stat_sat8, m_sat8);
        chk("stat_samples8", stat_samples8, m_samples);
        if (just_rst) begin
          chk("rst_out_sum", out_sum, 0);
          chk("rst_out_exact", out_exact, 0);
          chk("rst_out_err", out_err, 0);
          just_rst = 1'b0;
        end
        exp_ready = (q.size() < 2) || out_ready;
        chk("in_ready", in_ready, exp_ready);
        chk("in_ready8", in_ready8, exp_ready);
        ev = 1'b0;
        if (q.size() > 0) begin
          vis = (q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1;
          ev  = (vis <= cyc);
        end
        chk("out_valid", out_valid, ev);
        chk("out_valid8", out_valid8, ev);
        if (ev) begin
          h = q[0];
          chk("out_sum", out_sum, h.sum);
          chk("out_exact", out_exact, h.exact);
          chk("out_err", out_err, h.err);
          chk("out_sum8", out_sum8, h.sum);
          chk("out_err8", out_err8, h.err);
        end
        if (stat_clear) begin
          model_clear_stats();
        end else if (ev && out_ready) begin
          if (m_samples == 64'hFFFF_FFFF) m_sat = 1; else m_samples++;
          if (q[0].err != 0) begin
            if (m_errors == 64'hFFFF_FFFF) m_sat = 1; else m_errors++;
          end
          if (q[0].err > m_max) m_max = q[0].err;
          if (m_sum + q[0].err > 64'hFFFF_FFFF) begin m_sum = 64'hFFFF_FFFF; m_sat = 1; end
          else m_sum = m_sum + q[0].err;
          if (m_sum8 + q[0].err > 255) begin m_sum8 = 255; m_sat8 = 1; end
          else m_sum8 = m_sum8 + q[0].err;
          m_sat8 = m_sat8 | (m_samples == 64'hFFFF_FFFF);
        end
        if (ev && out_ready) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
        if (in_valid && exp_ready) q.push_back(model(in_a, in_b, in_mode, cyc));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends one pair into an idle pipeline and checks latency and literal results.
  task automatic send_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] m, input logic [W:0] esum,
                            input logic [W:0] eexact, input logic [W:0] eerr);
    send(a, b, m);
    @(negedge clk);
    chk({name, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat2_valid"}, out_valid, 1);
    chk({name, "_sum"}, out_sum, esum);
    chk({name, "_exact"}, out_exact, eexact);
    chk({name, "_err"}, out_err, eerr);
  endtask

  logic [W-1:0] pa [3];
  logic [W-1:0] pb [3];
  logic [1:0]   pm [3];

  initial begin : stim
    int idx;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    out_ready = 1'b1; stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);

    send_check("t1_mode0", 16'hFFFF, 16'h0001, 2'd0, 17'h10000, 17'h10000, 17'h0);
    send_check("t2_mode1", 16'h003F, 16'h0001, 2'd1, 17'h00000, 17'h00040, 17'h40);
    send_check("t3_mode2a", 16'h003F, 16'h0001, 2'd2, 17'h0003F, 17'h00040, 17'h1);
    send_check("t3_mode2b", 16'hFFC0, 16'h0040, 2'd2, 17'h10000, 17'h10000, 17'h0);
    @(negedge clk);
    chk("t5_samples", stat_samples, 4);
    chk("t5_errors", stat_errors, 2);
    chk("t5_max", stat_max_err, 64);
    chk("t5_sum", stat_sum_err, 65);

    // Stall: three pairs offered while the sink is blocked.
    pa[0] = 16'h1234; pb[0] = 16'h0FFF; pm[0] = 2'd0;
    pa[1] = 16'h00FF; pb[1] = 16'h00FF; pm[1] = 2'd1;
    pa[2] = 16'h0041; pb[2] = 16'h0082; pm[2] = 2'd2;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = (idx < 3); in_a = pa[idx % 3]; in_b = pb[idx % 3]; in_mode = pm[idx % 3];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    chk("t4_accepted", idx, 2);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_head_sum", out_sum, 17'h02233);
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = pa[idx]; in_b = pb[idx]; in_mode = pm[idx];
      @(negedge clk);
      if (in_ready) idx++;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_drained_samples", stat_samples, 7);
    chk("t4_max", stat_max_err, 17'h7E);

    // Clear coincident with a handshake.
    send(16'h003F, 16'h0001, 2'd1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("t5_clear_seen_valid", seen, 1);
    stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    @(negedge clk);
    chk("t5_clr_samples", stat_samples, 0);
    chk("t5_clr_errors", stat_errors, 0);
    chk("t5_clr_max", stat_max_err, 0);
    chk("t5_clr_sum", stat_sum_err, 0);
    chk("t5_clr_sat", stat_sat, 0);

    // Narrow accumulator saturation.
    repeat (5) send(16'h003F, 16'h0001, 2'd1);
    repeat (4) @(negedge clk);
    chk("t6_sum8", stat_sum_err8, 8'hFF);
    chk("t6_sat8", stat_sat8, 1);
    chk("t6_sum32", stat_sum_err, 320);
    chk("t6_sat32", stat_sat, 0);

    // Reset with two transactions in flight.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h1111, 16'h2222, 2'd0);
    send(16'h3333, 16'h4444, 2'd2);
    @(negedge clk);
    chk("t6_inflight_valid", out_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_samples", stat_samples, 0);
    chk("t6_rst_sum8", stat_sum_err8, 0);
    chk("t6_rst_sat8", stat_sat8, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;

    // Randomized traffic with back-pressure, occasional clears and resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_a       = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      in_b       = ($urandom_range(0, 7) == 0) ? 16'h0001 : W'($urandom);
      in_mode    = 2'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 3) != 0);
      stat_clear = ($urandom_range(0, 80) == 0);
      rst        = ($urandom_range(0, 250) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0; rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
